// File: rtl/tx_move_arbiter.sv
// rtl/tx_move_arbiter.sv - round-robin arbiter sharing one move transmitter among NUM_REQ sources
module tx_move_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int MOVE_W        = 22,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*MOVE_W-1:0]  move_bus,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       tx_start,
  output logic [MOVE_W-1:0]          tx_move,
  input  logic                       tx_idle,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int TMAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
  localparam int TW   = $clog2(TMAX) + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_IDLE = 3'd3,
    ACK       = 3'd4,
    GAP       = 3'd5
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [TW-1:0]  timer;
  logic [IDW-1:0] last;
  logic [IDW-1:0] pick_id;
  logic           pick_valid;
  logic           start_expired;
  logic           gap_done;

  // Lowest requester above last wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    pick_valid = |req;
    pick_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) pick_id = IDW'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(last))) pick_id = IDW'(i);
    end
  end

  assign start_expired = (timer == TW'(START_TIMEOUT - 1));
  assign gap_done      = (timer == TW'(GAP_CYCLES - 1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (pick_valid && tx_idle) next_state = ISSUE;
      ISSUE:     next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!tx_idle)          next_state = WAIT_IDLE;
        else if (start_expired) next_state = ACK;
      end
      WAIT_IDLE: if (tx_idle) next_state = ACK;
      ACK:       next_state = GAP;
      GAP:       if (gap_done) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      last        <= IDW'(NUM_REQ - 1);
      grant_id    <= '0;
      tx_move     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (pick_valid && tx_idle) begin
            grant_id <= pick_id;
            tx_move  <= move_bus[int'(pick_id)*MOVE_W +: MOVE_W];
          end
        end
        ISSUE: timer <= '0;
        WAIT_BUSY: begin
          // A transmitter that never leaves idle is treated as having dropped the message.
          if (tx_idle) begin
            if (start_expired) timeout_err <= 1'b1;
            else               timer       <= timer + TW'(1);
          end
        end
        ACK: begin
          last  <= grant_id;
          timer <= '0;
        end
        GAP: timer <= timer + TW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    ack = '0;
    if (state == ACK) ack[grant_id] = 1'b1;
  end

  assign tx_start = (state == ISSUE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_tx_move_arbiter.sv
// tb/tb_tx_move_arbiter.sv - scoreboard bench for tx_move_arbiter
module tb_tx_move_arbiter;
  localparam int N   = 2;
  localparam int W   = 22;
  localparam int IDW = 1;

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   mv;
  } start_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   move_bus = '0;
  logic [N-1:0]     ack;
  logic             tx_start;
  logic [W-1:0]     tx_move;
  logic             tx_idle = 1'b1;
  logic             busy;
  logic [IDW-1:0]   grant_id;
  logic             timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int ack_cnt = 0;
  int last_start_cyc = 0;
  int last_ack_cyc = 0;
  bit tx_stuck = 1'b0;

  start_t       exp_start[$];
  logic [N-1:0] exp_ack[$];

  tx_move_arbiter #(.NUM_REQ(N), .MOVE_W(W), .GAP_CYCLES(16), .START_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .req(req), .move_bus(move_bus), .ack(ack),
    .tx_start(tx_start), .tx_move(tx_move), .tx_idle(tx_idle), .busy(busy),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic set_move(input int i, input logic [W-1:0] m);
    move_bus[i*W +: W] = m;
  endtask

  task automatic push_start(input int id, input logic [W-1:0] m);
    start_t e;
    e.id = IDW'(id);
    e.mv = m;
    exp_start.push_back(e);
  endtask

  task automatic wait_ack(input int target, input string nm);
    int n = 0;
    while (ack_cnt < target && n < 400) begin step(); n++; end
    check(ack_cnt >= target, nm, ack_cnt, target);
  endtask

  task automatic wait_start(input int target, input string nm);
    int n = 0;
    while (start_cnt < target && n < 400) begin step(); n++; end
    check(start_cnt >= target, nm, start_cnt, target);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 400) begin step(); n++; end
    check(!busy, nm, busy, 0);
  endtask

  // Transmitter model: leaves idle one cycle after start and stays busy for 20 cycles.
  initial forever begin
    @(negedge clock);
    if (tx_start && !tx_stuck) begin
      tx_idle = 1'b0;
      repeat (20) @(negedge clock);
      tx_idle = 1'b1;
    end
  end

  // Monitor: pops expectations whenever the DUT issues a start or an ack.
  initial forever begin
    @(negedge clock);
    cyc++;
    if (tx_start || ack != '0)
      check(!(tx_start && ack != '0) && $countones(ack) <= 1, "ack_start_excl", {tx_start, ack}, 0);
    if (tx_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      if (exp_start.size() == 0) check(1'b0, "unexpected_start", tx_move, 0);
      else begin
        start_t e;
        e = exp_start.pop_front();
        check(tx_move === e.mv && grant_id === e.id, "start_move", {grant_id, tx_move}, {e.id, e.mv});
      end
    end
    if (ack != '0) begin
      ack_cnt++;
      last_ack_cyc = cyc;
      if (exp_ack.size() == 0) check(1'b0, "unexpected_ack", ack, 0);
      else begin
        logic [N-1:0] ea;
        ea = exp_ack.pop_front();
        check(ack === ea, "ack_bits", ack, ea);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=%0d expected=done", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int a1;
    int a0;
    reset = 1'b0;
    step(); step();
    check(ack == '0, "rst_ack", ack, 0);
    check(tx_start == 1'b0, "rst_tx_start", tx_start, 0);
    check(tx_move == '0, "rst_tx_move", tx_move, 0);
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(grant_id == '0, "rst_grant_id", grant_id, 0);
    check(timeout_err == 1'b0, "rst_timeout_err", timeout_err, 0);
    reset = 1'b1;
    step();

    // 1: single request, full message, 16-cycle gap
    set_move(0, 22'h0ABCDE);
    push_start(0, 22'h0ABCDE);
    exp_ack.push_back(2'b01);
    req = 2'b01;
    n = 0;
    while (start_cnt < 1 && n < 10) begin step(); n++; end
    check(n >= 1 && n <= 2, "t1_start_latency", n, 2);
    wait_ack(1, "t1_ack_wait");
    check(last_ack_cyc - last_start_cyc == 21, "t1_start_to_ack", last_ack_cyc - last_start_cyc, 21);
    req = 2'b00;
    repeat (16) step();
    check(busy == 1'b1, "t1_gap_last_busy", busy, 1);
    step();
    check(busy == 1'b0, "t1_gap_end_idle", busy, 0);

    // 2: both held after reset -> 0,1,0,1
    reset = 1'b0; step(); reset = 1'b1; step();
    set_move(0, 22'h011111);
    set_move(1, 22'h022222);
    for (int k = 0; k < 4; k++) begin
      push_start(k % 2, (k % 2 == 0) ? 22'h011111 : 22'h022222);
      exp_ack.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
    end
    req = 2'b11;
    wait_ack(ack_cnt + 4, "t2_ack_wait");
    req = 2'b00;
    wait_idle("t2_idle");

    // 3: transmitter never leaves idle -> timeout, ack still issued, next request served
    tx_stuck = 1'b1;
    set_move(0, 22'h033333);
    push_start(0, 22'h033333);
    exp_ack.push_back(2'b01);
    req = 2'b01;
    wait_ack(ack_cnt + 1, "t3_ack_wait");
    check(last_ack_cyc - last_start_cyc == 9, "t3_timeout_len", last_ack_cyc - last_start_cyc, 9);
    check(timeout_err == 1'b1, "t3_timeout_err", timeout_err, 1);
    req = 2'b00;
    wait_idle("t3_idle");
    tx_stuck = 1'b0;
    set_move(1, 22'h044444);
    push_start(1, 22'h044444);
    exp_ack.push_back(2'b10);
    req = 2'b10;
    wait_ack(ack_cnt + 1, "t3_next_ack");
    req = 2'b00;
    wait_idle("t3_next_idle");
    check(timeout_err == 1'b1, "t3_err_sticky", timeout_err, 1);

    // 4: tx_idle low blocks the grant
    tx_idle = 1'b0;
    set_move(0, 22'h055555);
    push_start(0, 22'h055555);
    exp_ack.push_back(2'b01);
    n = start_cnt;
    req = 2'b01;
    repeat (5) step();
    check(busy == 1'b0 && start_cnt == n, "t4_blocked", {busy, start_cnt[7:0]}, n);
    tx_idle = 1'b1;
    step();
    check(busy == 1'b1 && start_cnt == n + 1, "t4_grant_after_idle", start_cnt, n + 1);
    wait_ack(ack_cnt + 1, "t4_ack_wait");
    req = 2'b00;
    wait_idle("t4_idle");

    // 5: req0 withdrawn mid-message still acked; pending req1 served after gap
    set_move(0, 22'h066666);
    set_move(1, 22'h077777);
    push_start(0, 22'h066666);
    exp_ack.push_back(2'b01);
    push_start(1, 22'h077777);
    exp_ack.push_back(2'b10);
    req = 2'b01;
    wait_start(start_cnt + 1, "t5_start0");
    req = 2'b11;
    repeat (3) step();
    req = 2'b10;
    wait_ack(ack_cnt + 1, "t5_ack0");
    a1 = last_ack_cyc;
    wait_start(start_cnt + 1, "t5_start1");
    check(last_start_cyc - a1 == 18, "t5_gap_to_start", last_start_cyc - a1, 18);
    wait_ack(ack_cnt + 1, "t5_ack1");
    req = 2'b00;
    wait_idle("t5_idle");

    // 6: reset during WAIT_IDLE clears outputs at once, no ack
    set_move(0, 22'h0FEDCB);
    push_start(0, 22'h0FEDCB);
    req = 2'b01;
    wait_start(start_cnt + 1, "t6_start");
    repeat (4) step();
    a0 = ack_cnt;
    reset = 1'b0;
    #1;
    check(busy == 1'b0 && tx_start == 1'b0 && ack == '0, "t6_rst_ctrl", {busy, tx_start, ack}, 0);
    check(tx_move == '0, "t6_rst_tx_move", tx_move, 0);
    check(grant_id == '0, "t6_rst_grant_id", grant_id, 0);
    check(timeout_err == 1'b0, "t6_rst_timeout_err", timeout_err, 0);
    req = 2'b00;
    step(); step();
    reset = 1'b1;
    repeat (30) step();
    check(ack_cnt == a0, "t6_no_ack", ack_cnt, a0);
    check(exp_start.size() == 0 && exp_ack.size() == 0, "queues_drained",
          exp_start.size() + exp_ack.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
